pdm_output_stage: RTL

Final audio output stage: takes the signed mix sample from the channel mixer, applies a click-free mute/unmute gain ramp, and converts the result to a 1-bit pulse-density stream via a first-order sigma-delta modulator. Sits directly downstream of the mixer and drives the FPGA audio pin, which feeds an external RC low-pass filter.

---
 rtl/pdm_output_stage.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/pdm_output_stage.sv
// Final audio output stage: mute/unmute gain ramp plus first-order sigma-delta PDM modulator.
// Optional LFSR dither on the modulator input is enabled by defining TINY_SYNTH_PDM_DITHER_EN.
module pdm_output_stage #(
  parameter int unsigned DATA_BITS = 12,
  parameter int unsigned GAIN_BITS = 4,
  parameter int unsigned RAMP_DIV  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] din,
  input  logic                 din_valid,
  input  logic                 mute,
  output logic                 pdm_out,
  output logic                 muted,
  output logic                 ramping
);
  localparam int unsigned GW    = GAIN_BITS + 1;
  localparam int unsigned PW    = DATA_BITS + GW + 1;
  localparam int unsigned DIV_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;

  localparam logic [GW-1:0]        GAIN_UNITY   = {1'b1, {GAIN_BITS{1'b0}}};
  localparam logic [GW-1:0]        GAIN_PRE_TOP = GAIN_UNITY - GW'(1);
  localparam logic [DIV_W-1:0]     DIV_LAST     = DIV_W'(RAMP_DIV - 1);
  localparam logic [DATA_BITS-1:0] MIDSCALE     = {1'b1, {(DATA_BITS-1){1'b0}}};

  typedef enum logic [1:0] {
    S_MUTED     = 2'd0,
    S_RAMP_UP   = 2'd1,
    S_ACTIVE    = 2'd2,
    S_RAMP_DOWN = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [GW-1:0]        gain_q, gain_d;
  logic [DIV_W-1:0]     div_q, div_d;
  logic                 tick;
  logic                 muted_d, ramping_d;

  logic [DATA_BITS-1:0] hold;
  logic [DATA_BITS-1:0] u_q;
  logic [DATA_BITS-1:0] u_mod;
  logic [DATA_BITS-1:0] acc;
  logic [DATA_BITS:0]   acc_next;

  logic signed [PW-1:0] hold_x, gain_x, product;
  logic [DATA_BITS-1:0] scaled, u;
  logic                 unused_bits;

  // Gain FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_MUTED;
      gain_q  <= '0;
      div_q   <= '0;
      muted   <= 1'b1;
      ramping <= 1'b0;
    end else begin
      state_q <= state_d;
      gain_q  <= gain_d;
      div_q   <= div_d;
      muted   <= muted_d;
      ramping <= ramping_d;
    end
  end

  // Next state; a mute change beats a coincident tick, and ramp ends saturate at 0 / unity
  always_comb begin
    state_d = state_q;
    gain_d  = gain_q;
    div_d   = '0;
    tick    = (div_q == DIV_LAST);
    if (state_q == S_RAMP_UP || state_q == S_RAMP_DOWN)
      div_d = tick ? '0 : div_q + DIV_W'(1);
    case (state_q)
      S_MUTED: begin
        gain_d = '0;
        if (!mute) state_d = S_RAMP_UP;
      end
      S_RAMP_UP: begin
        if (mute) begin
          state_d = S_RAMP_DOWN;
        end else if (tick) begin
          if (gain_q >= GAIN_PRE_TOP) begin
            gain_d  = GAIN_UNITY;
            state_d = S_ACTIVE;
          end else begin
            gain_d = gain_q + GW'(1);
          end
        end
      end
      S_ACTIVE: begin
        gain_d = GAIN_UNITY;
        if (mute) state_d = S_RAMP_DOWN;
      end
      S_RAMP_DOWN: begin
        if (!mute) begin
          state_d = S_RAMP_UP;
        end else if (tick) begin
          if (gain_q <= GW'(1)) begin
            gain_d  = '0;
            state_d = S_MUTED;
          end else begin
            gain_d = gain_q - GW'(1);
          end
        end
      end
      default: begin
        state_d = S_MUTED;
        gain_d  = '0;
      end
    endcase
    muted_d   = (state_d == S_MUTED);
    ramping_d = (state_d == S_RAMP_UP) || (state_d == S_RAMP_DOWN);
  end

  // Signed scale by gain, floor shift, then offset-binary conversion
  assign hold_x      = {{(PW-DATA_BITS){hold[DATA_BITS-1]}}, hold};
  assign gain_x      = {{(PW-GW){1'b0}}, gain_q};
  assign product     = hold_x * gain_x;
  assign scaled      = product[GAIN_BITS +: DATA_BITS];
  assign u           = {~scaled[DATA_BITS-1], scaled[DATA_BITS-2:0]};
  assign unused_bits = ^{product[PW-1:GAIN_BITS+DATA_BITS], product[GAIN_BITS-1:0]};

`ifdef TINY_SYNTH_PDM_DITHER_EN
  logic [15:0] lfsr;

  always_ff @(posedge clk) begin
    if (rst) lfsr <= 16'hACE1;
    else     lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
  end

  assign u_mod = (&u_q) ? u_q : u_q + DATA_BITS'(lfsr[0]);
`else
  assign u_mod = u_q;
`endif

  assign acc_next = {1'b0, acc} + {1'b0, u_mod};

  // Sample hold, u pipeline register and modulator accumulator
  always_ff @(posedge clk) begin
    if (rst) begin
      hold    <= '0;
      u_q     <= MIDSCALE;
      acc     <= '0;
      pdm_out <= 1'b0;
    end else begin
      if (din_valid) hold <= din;
      u_q     <= u;
      acc     <= acc_next[DATA_BITS-1:0];
      pdm_out <= acc_next[DATA_BITS];
    end
  end

endmodule
